// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shifter: shift modes and FSM states.
package seq_shift_unit_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle for the shifter: input handshake with operands,
// output handshake with result and status flags.
interface seq_shift_unit_if
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_e        mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               carry;

    // Requester / consumer side
    modport master (
        output in_valid, a, shamt, mode, out_ready,
        input  in_ready, out_valid, result, zero, carry
    );

    // Shifter side
    modport slave (
        input  in_valid, a, shamt, mode, out_ready,
        output in_ready, out_valid, result, zero, carry
    );
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// One combinational shift step of 0..STEP bits, returning the shifted data
// and the last bit pushed out (0 when k is 0).
module seq_shift_unit_shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  shift_mode_e      mode_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);
    logic [WIDTH:0]          ext_left;
    logic [WIDTH:0]          ext_right;
    logic [2*WIDTH-1:0]      doubled;
    logic signed [WIDTH-1:0] sdata;

    // Widened shifts capture the outgoing bit without variable part-selects;
    // the doubled word turns a rotate into a plain right shift.
    always_comb begin
        ext_left  = {1'b0, data_i} << k_i;
        ext_right = {data_i, 1'b0} >> k_i;
        doubled   = {data_i, data_i} >> k_i;
        sdata     = data_i;
        data_o    = data_i;
        carry_o   = 1'b0;
        case (mode_i)
            SH_SLL: begin
                data_o  = ext_left[WIDTH-1:0];
                carry_o = ext_left[WIDTH];
            end
            SH_SRL: begin
                data_o  = ext_right[WIDTH:1];
                carry_o = ext_right[0];
            end
            SH_SRA: begin
                data_o  = sdata >>> k_i;
                carry_o = ext_right[0];
            end
            SH_ROR: begin
                data_o  = doubled[WIDTH-1:0];
                carry_o = ext_right[0];
            end
            default: begin
                data_o  = data_i;
                carry_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shifter: accepts one request, shifts at most STEP bits per clock,
// then presents the result with Zero/Carry until the consumer takes it.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_shift_unit_if.slave bus
);
    localparam int KW = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0]   STEP_X    = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_X   = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   data_q,   data_d;
    shift_mode_e        mode_q,   mode_d;
    logic [SHAMT_W-1:0] rem_q,    rem_d;
    logic               carry_q,  carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;

    logic               accept;
    logic [SHAMT_W-1:0] shamt_sat;
    logic [SHAMT_W:0]   k_x;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Out-of-range amounts (only possible for non power-of-two WIDTH) clamp to WIDTH-1
    always_comb begin
        shamt_sat = bus.shamt;
        if ({1'b0, bus.shamt} >= WIDTH_X) begin
            shamt_sat = SHAMT_MAX;
        end
    end

    // This cycle's step size: whatever is left, capped at STEP
    always_comb begin
        k_x = ({1'b0, rem_q} < STEP_X) ? {1'b0, rem_q} : STEP_X;
        k   = KW'(k_x);
    end

    seq_shift_unit_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i  (data_q),
        .k_i     (k),
        .mode_i  (mode_q),
        .data_o  (step_data),
        .carry_o (step_carry)
    );

    // FSM next state: latch the request, iterate steps, publish on entry to DONE
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mode_d   = mode_q;
        rem_d    = rem_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = bus.a;
                    mode_d  = bus.mode;
                    rem_d   = shamt_sat;
                    carry_d = 1'b0;
                    if (shamt_sat == '0) begin
                        state_d  = ST_DONE;
                        result_d = bus.a;
                        zero_d   = (bus.a == '0);
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d  = step_data;
                carry_d = step_carry;
                rem_d   = rem_q - k_x[SHAMT_W-1:0];
                if ({1'b0, rem_q} == k_x) begin
                    state_d  = ST_DONE;
                    result_d = step_data;
                    zero_d   = (step_data == '0);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            mode_q   <= SH_SLL;
            rem_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=16, STEP=4).
module tb_seq_shift_unit;
    import seq_shift_unit_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_shift_unit_if #(.WIDTH(16), .SHAMT_W(4)) bus ();

    seq_shift_unit #(
        .WIDTH   (16),
        .SHAMT_W (4),
        .STEP    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] a;
        int          shamt;
        logic [15:0] exp_r;
        logic        exp_z;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built straight from the arithmetic definition of each mode
    function automatic void model(input logic [1:0] m, input logic [15:0] a, input int s,
                                  output logic [15:0] r, output logic c);
        logic [31:0] w;
        int          sv;
        r = a;
        c = 1'b0;
        case (m)
            2'b00: begin
                w = {16'h0, a} << s;
                r = w[15:0];
                c = (s == 0) ? 1'b0 : w[16];
            end
            2'b01: begin
                r = a >> s;
                c = (s == 0) ? 1'b0 : a[s-1];
            end
            2'b10: begin
                sv = int'($signed(a));
                sv = sv >>> s;
                r  = sv[15:0];
                c  = (s == 0) ? 1'b0 : a[s-1];
            end
            default: begin
                w = {a, a} >> s;
                r = w[15:0];
                c = (s == 0) ? 1'b0 : r[15];
            end
        endcase
    endfunction

    function automatic int exp_latency(input int s);
        return (s == 0) ? 1 : 1 + (s + 3) / 4;
    endfunction

    // One request through the unit with OutReady held high; returns the
    // number of cycles from the accept edge until OutValid is seen.
    task automatic do_op(input logic [1:0] m, input logic [15:0] a, input int s,
                         output int lat, output logic [15:0] r, output logic z, output logic c);
        int guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode     = shift_mode_e'(m);
        bus.a        = a;
        bus.shamt    = 4'(s);
        guard        = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.shamt    = 4'($urandom);
        bus.mode     = shift_mode_e'(2'($urandom));
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        r = bus.result;
        z = bus.zero;
        c = bus.carry;
        $display("op mode=%0d a=%h shamt=%0d -> result=%h zero=%b carry=%b lat=%0d",
                 m, a, s, r, z, c, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        logic [15:0] r;
        logic        z;
        logic        c;
        logic [15:0] er;
        logic        ec;
        logic [15:0] a_rnd;

        total = 0;
        bad   = 0;

        vecs[0] = '{2'b10, 16'hC001, 15, 16'hFFFF, 1'b0, 1'b1, 5};
        vecs[1] = '{2'b00, 16'h0001,  0, 16'h0001, 1'b0, 1'b0, 1};
        vecs[2] = '{2'b00, 16'h8000,  1, 16'h0000, 1'b1, 1'b1, 2};
        vecs[3] = '{2'b11, 16'h1234,  4, 16'h4123, 1'b0, 1'b0, 2};
        vecs[4] = '{2'b01, 16'h8000, 15, 16'h0001, 1'b0, 1'b0, 5};
        vecs[5] = '{2'b10, 16'h7FF0,  5, 16'h03FF, 1'b0, 1'b1, 3};
        vecs[6] = '{2'b11, 16'h0001,  8, 16'h0100, 1'b0, 1'b0, 3};
        vecs[7] = '{2'b10, 16'h8001,  1, 16'hC000, 1'b0, 1'b1, 2};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.shamt     = '0;
        bus.mode      = SH_SLL;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    {16'd0, bus.result},    32'd0);
        chk("rst_zero",      {31'd0, bus.zero},      32'd0);
        chk("rst_carry",     {31'd0, bus.carry},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].mode, vecs[i].a, vecs[i].shamt, lat, r, z, c);
            chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].exp_r});
            chk($sformatf("vec%0d_zero", i),   {31'd0, z}, {31'd0, vecs[i].exp_z});
            chk($sformatf("vec%0d_carry", i),  {31'd0, c}, {31'd0, vecs[i].exp_c});
            chk($sformatf("vec%0d_lat", i),    lat,        vecs[i].exp_lat);
        end

        // Backpressure: result held, second request waits until IDLE
        begin
            int guard;
            bus.out_ready = 1'b0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.mode     = SH_SRL;
            bus.a        = 16'h00F0;
            bus.shamt    = 4'd4;
            @(posedge clk);
            #1;
            bus.mode  = SH_SLL;
            bus.a     = 16'h0003;
            bus.shamt = 4'd2;
            guard = 0;
            while (guard < 20) begin
                @(negedge clk);
                guard++;
                if (bus.out_valid) break;
            end
            chk("bp_latency", guard, 2);
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                chk($sformatf("bp_hold%0d_valid", i),  {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("bp_hold%0d_result", i), {16'd0, bus.result},    32'h000F);
                chk($sformatf("bp_hold%0d_ready", i),  {31'd0, bus.in_ready},  32'd0);
                $display("bp hold cycle %0d result=%h in_ready=%b", i, bus.result, bus.in_ready);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            guard = 0;
            while (guard < 20) begin
                @(negedge clk);
                guard++;
                if (bus.out_valid) break;
            end
            chk("bp_queued_lat",    guard, 2);
            chk("bp_queued_result", {16'd0, bus.result}, 32'h000C);
            $display("bp queued op result=%h lat=%0d", bus.result, guard);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode     = SH_SRA;
        bus.a        = 16'h8000;
        bus.shamt    = 4'd12;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_result", {16'd0, bus.result},    32'd0);
        chk("midrst_valid",  {31'd0, bus.out_valid}, 32'd0);
        $display("mid-shift reset result=%h out_valid=%b", bus.result, bus.out_valid);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
        do_op(2'b00, 16'h0003, 2, lat, r, z, c);
        chk("postrst_result", {16'd0, r}, 32'h000C);
        chk("postrst_lat",    lat,        2);

        // Randomized sweep against the reference model
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 16; s++) begin
                a_rnd = 16'($urandom);
                if ((s % 7) == 3) a_rnd = '0;
                model(2'(m), a_rnd, s, er, ec);
                do_op(2'(m), a_rnd, s, lat, r, z, c);
                chk($sformatf("sweep_m%0d_s%0d_result", m, s), {16'd0, r}, {16'd0, er});
                chk($sformatf("sweep_m%0d_s%0d_carry", m, s),  {31'd0, c}, {31'd0, ec});
                chk($sformatf("sweep_m%0d_s%0d_zero", m, s),   {31'd0, z}, {31'd0, (er == 16'd0)});
                chk($sformatf("sweep_m%0d_s%0d_lat", m, s),    lat,        exp_latency(s));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised, multi-cycle barrel/iterative shifter for the CPU execute stage.
- Supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Shifts at most STEP bits per clock, which trades latency for area.
- Uses valid/ready handshakes on both input and output, and produces Zero and Carry flags for the status register.

Parameters:
- WIDTH, 16: operand/result width in bits (>=2).
- SHAMT_W, $clog2(WIDTH): shift-amount width; legal amounts are 0..WIDTH-1.
- STEP, 4: maximum bits shifted per cycle; 1 <= STEP <= WIDTH.

Ports:
- Clock  input  1  single clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  request valid.
- InReady  output  1  unit can accept a request.
- A  input  WIDTH  operand.
- Shamt  input  SHAMT_W  shift amount.
- Mode  input  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Result  output  WIDTH  shifted value.
- Zero  output  1  Result == 0.
- Carry  output  1  last bit shifted or rotated out.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; Result, Zero, Carry, OutValid = 0; InReady = 1 once Reset deasserts. Reset mid-operation aborts immediately and discards the operand.
- States: IDLE, SHIFT, DONE.
- InReady = (state == IDLE). A request is accepted only when InValid && InReady.
- Accept in cycle T: register A, Mode and Shamt (Remaining); clear Carry.
  - Shamt == 0: go to DONE.
  - Shamt != 0: go to SHIFT.
- SHIFT, each cycle:
  - k = min(Remaining, STEP); shift the data register by k per Mode; Remaining -= k.
  - When Remaining == k, go to DONE.
- Per-step shift rules:
  - SLL: zero-fill the LSBs; Carry = Data[WIDTH-k].
  - SRL: zero-fill the MSBs; Carry = Data[k-1].
  - SRA: fill the MSBs with Data[WIDTH-1] (the original sign is preserved through every step); Carry = Data[k-1].
  - ROR: Data[k-1:0] moves to the MSBs; Carry = Data[k-1], which equals Result[WIDTH-1] after the final step.
- Latency from the accept edge to OutValid = 1:
  - Shamt == 0: 1 cycle.
  - Otherwise: 1 + ceil(Shamt/STEP) cycles.
  - WIDTH=16, STEP=4, Shamt=15: OutValid at T+5.
- DONE:
  - OutValid = 1; Result = data register; Zero = (Result == 0); Carry holds.
  - Result, Zero and Carry are stable while OutReady = 0 (backpressure has no cycle limit).
  - DONE && OutReady: go to IDLE next cycle; OutValid drops. A new accept is possible in the cycle after.
- The unit does not overlap operations; at most one is in flight.
- Inputs A, Shamt and Mode are don't-care outside the accept cycle. Changing them during SHIFT/DONE has no effect.
- InValid while busy is ignored; the requester must hold it until InReady.
- Mode/Shamt are not re-sampled mid-shift.
- Result, Zero and Carry hold their last values in IDLE until the next DONE updates them.
- Shamt values >= WIDTH are unrepresentable when WIDTH is a power of two. For other WIDTH, an amount >= WIDTH is treated as WIDTH-1 (saturated at accept).

Decomposition:
- Shared package holds:
  - Mode encodings: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - State encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module, shift_step: combinational shift by k (0..STEP) for a given Mode, returning the shifted data and the carry bit. It is reused once per cycle.
- The top level holds the FSM, the Remaining counter, the data/carry registers and the handshakes.

Test Plan (WIDTH=16, STEP=4):
- SRA, A=0xC001, Shamt=15, accept at T -> OutValid at T+5, Result=0xFFFF, Carry=1, Zero=0.
- SLL, A=0x0001, Shamt=0 -> OutValid at T+1, Result=0x0001, Carry=0, Zero=0. Then SLL, A=0x8000, Shamt=1 -> Result=0x0000, Zero=1, Carry=1, OutValid at T+2.
- ROR, A=0x1234, Shamt=4 -> Result=0x4123, Carry=0, OutValid at T+2. Then SRL, A=0x8000, Shamt=15 -> Result=0x0001, Carry=0, OutValid at T+5.
- Backpressure: SRL, A=0x00F0, Shamt=4, hold OutReady=0 for 3 cycles after OutValid -> Result=0x000F held stable, InReady=0, a second InValid is ignored. Raise OutReady -> OutValid=0 next cycle and InReady=1; the queued request is then accepted.
- Reset mid-SHIFT: SRA, A=0x8000, Shamt=12, assert Reset asynchronously at T+2 -> Result=0, OutValid=0 immediately. After release, InReady=1 and a fresh SLL, A=0x0003, Shamt=2 -> Result=0x000C at T'+2.
- Sweep: all 4 modes x Shamt 0..15 x random A -> Result and Carry match the golden model, and latency = 1 + ceil(Shamt/4) (1 for Shamt=0).
